// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage, one result bit per cycle.
// Optional build macro MDU_EARLY_TERM_EN ends MUL early once no multiplier bits remain.
module ex_muldiv #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       rd_in,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       rd_out,
  output logic [1:0]       alu_status
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DONE = 2'b01,
    S_BUSY = 2'b10,
    S_LAST = 2'b11
  } state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [3:0]       rd_q, rd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       rd_out_q, rd_out_d;

  logic [WIDTH-1:0] hi_step, lo_step, m_step, final_res;
  logic [WIDTH:0]   mul_sum, div_shift;

  // One iteration. MUL accumulates a left-shifting multiplicand so it can stop early;
  // MULH uses a right-shifting {hi,lo} product; DIV/REM keep remainder in hi, quotient in lo.
  always_comb begin
    hi_step   = hi_q;
    lo_step   = lo_q;
    m_step    = m_q;
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : {WIDTH{1'b0}})};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    case (op_q)
      OP_MUL: begin
        hi_step = lo_q[0] ? hi_q + m_q : hi_q;
        m_step  = m_q << 1;
        lo_step = lo_q >> 1;
      end
      OP_MULH: begin
        hi_step = mul_sum[WIDTH:1];
        lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
      default: begin
        if (div_shift >= {1'b0, m_q}) begin
          hi_step = div_shift[WIDTH-1:0] - m_q;
          lo_step = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_step = div_shift[WIDTH-1:0];
          lo_step = {lo_q[WIDTH-2:0], 1'b0};
        end
      end
    endcase
    final_res = (op_q == OP_DIV) ? lo_step : hi_step;
  end

  // Next-state and register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    result_d = result_q;
    rd_out_d = 4'd0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          op_d  = op;
          rd_d  = rd_in;
          cnt_d = CNT_W'(WIDTH - 1);
          if (op[1] && (operand_b == '0)) begin
            state_d  = S_DONE;
            result_d = op[0] ? operand_a : {WIDTH{1'b1}};
            rd_out_d = rd_in;
          end else begin
            state_d = S_BUSY;
            hi_d    = '0;
            lo_d    = op[1] ? operand_a : operand_b;
            m_d     = op[1] ? operand_b : operand_a;
          end
        end
      end
      S_BUSY: begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        m_d   = m_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_LAST;
`ifdef MDU_EARLY_TERM_EN
        if ((op_q == OP_MUL) && (lo_step == '0)) state_d = S_LAST;
`endif
      end
      S_LAST: begin
        hi_d     = hi_step;
        lo_d     = lo_step;
        m_d      = m_step;
        state_d  = S_DONE;
        result_d = final_res;
        rd_out_d = rd_q;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything, including a same-cycle start.
    if (flush) begin
      state_d  = S_IDLE;
      rd_out_d = 4'd0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign alu_status = state_q;
  assign result     = result_q;
  assign rd_out     = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expected results, a negedge monitor checks them.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] operand_a = '0;
  logic [15:0] operand_b = '0;
  logic [3:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic [15:0] result;
  logic [3:0]  rd_out;
  logic [1:0]  alu_status;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  rd;
    logic [7:0]  stall;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          stall_cnt = 0;
  logic [15:0] last_res = '0;

  ex_muldiv dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in), .flush(flush),
    .result(result), .rd_out(rd_out), .alu_status(alu_status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [15:0] model_res(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'd0, a} * {16'd0, b};
    case (o)
      2'b00:   return p[15:0];
      2'b01:   return p[31:16];
      2'b10:   return (b == 0) ? 16'hFFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_stall(input logic [1:0] o, input logic [15:0] b);
    int busy;
    if (o[1] && b == 0) return 0;
    busy = 16;
`ifdef MDU_EARLY_TERM_EN
    if (o == 2'b00) begin
      busy = 1;
      for (int i = 0; i < 16; i++) if (b[i]) busy = i + 1;
      if (busy > 15) busy = 15;
      busy = busy + 1;
    end
`endif
    return busy;
  endfunction

  // Waits for IDLE/DONE, issues one op, returns in cycle 1 of that op.
  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input logic [3:0] r);
    int n;
    exp_t e;
    n = 0;
    while (alu_status[1] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("issue_timeout", 32'(n), 0);
    start = 1'b1; op = o; operand_a = a; operand_b = b; rd_in = r;
    e.res = model_res(o, a, b); e.rd = r; e.stall = 8'(model_stall(o, b));
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("status_after_start", 32'(alu_status), (o[1] && b == 0) ? 32'h1 : 32'h2);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (alu_status != 2'b01 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("done_timeout", 32'(n), 0);
  endtask

  // Monitor: pop and compare on every DONE, verify quiet outputs otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_res  = '0;
      stall_cnt = 0;
    end else begin
      if (alu_status == 2'b01) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(result), 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("rd_out", 32'(rd_out), 32'(e.rd));
          chk("stall_len", 32'(stall_cnt), 32'(e.stall));
          last_res = e.res;
        end
        stall_cnt = 0;
      end else begin
        chk("rd_out_idle", 32'(rd_out), 0);
        chk("result_hold", 32'(result), 32'(last_res));
        if (alu_status[1]) stall_cnt++;
        else stall_cnt = 0;
      end
    end
  end

  initial begin
    logic [15:0] ra, rb;
    logic [1:0]  ro;
    int          n;
    #1;
    chk("reset_status", 32'(alu_status), 0);
    chk("reset_result", 32'(result), 0);
    chk("reset_rd", 32'(rd_out), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MUL 7*9, then IDLE right after DONE.
    issue(2'b00, 16'd7, 16'd9, 4'd3);
    wait_done();
    chk("mul_direct", 32'(result), 32'h3F);
    @(posedge clk); #1;
    chk("idle_after_done", 32'(alu_status), 0);

    issue(2'b01, 16'hFFFF, 16'hFFFF, 4'd1);
    issue(2'b00, 16'hFFFF, 16'hFFFF, 4'd2);
    issue(2'b10, 16'd100, 16'd7, 4'd4);
    issue(2'b11, 16'd100, 16'd7, 4'd5);
    issue(2'b10, 16'h1234, 16'd0, 4'd6);
    issue(2'b11, 16'h1234, 16'd0, 4'd7);
    wait_done();
    @(posedge clk); #1;

    // Flush at cycle 5 of a DIV.
    issue(2'b10, 16'd5000, 16'd3, 4'd8);
    void'(exp_q.pop_back());
    repeat (4) begin @(posedge clk); #1; end
    chk("flush_pre_status", 32'(alu_status), 2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_status", 32'(alu_status), 0);
    chk("flush_rd", 32'(rd_out), 0);

    // start together with flush stays IDLE.
    start = 1'b1; flush = 1'b1; op = 2'b00; operand_a = 16'd3; operand_b = 16'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("start_flush_status", 32'(alu_status), 0);
    @(posedge clk); #1;
    chk("start_flush_status2", 32'(alu_status), 0);

    // start during BUSY is ignored.
    issue(2'b01, 16'hABCD, 16'h9876, 4'd9);
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; op = 2'b10; operand_a = 16'd1; operand_b = 16'd1; rd_in = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;

    // Back-to-back from DONE.
    wait_done();
    issue(2'b11, 16'd999, 16'd10, 4'd10);
    wait_done();
    @(posedge clk); #1;

    // Reset pulse mid-MUL clears outputs at once.
    issue(2'b00, 16'h1111, 16'hFFFF, 4'd11);
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("rst_mid_status", 32'(alu_status), 0);
    chk("rst_mid_result", 32'(result), 0);
    chk("rst_mid_rd", 32'(rd_out), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef MDU_EARLY_TERM_EN
    issue(2'b00, 16'd21, 16'd3, 4'd12);
    @(posedge clk); #1;
    chk("et_c2", 32'(alu_status), 2);
    @(posedge clk); #1;
    chk("et_c3", 32'(alu_status), 3);
    @(posedge clk); #1;
    chk("et_c4", 32'(alu_status), 1);
`endif

    // Randomized traffic with occasional zero divisors and back-to-back issue.
    for (int k = 0; k < 60; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 16'd0;
        1:       rb = 16'($urandom_range(1, 15));
        2:       rb = 16'hFFFF;
        default: rb = 16'($urandom);
      endcase
      issue(ro, ra, rb, 4'($urandom));
      repeat ($urandom_range(0, 1) * $urandom_range(1, 20)) begin @(posedge clk); #1; end
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
